pd_vote: RTL and testbench
==========================

# pd_vote

Parametrised majority-vote phase detector for the FMDLL loop. It samples `clk_out` with `clk_ext` at a programmable (M, N) counter position, but only while the delay code is settled (`Q == Q_next`). It accumulates the samples over a fixed vote window and issues filtered lead/lag decisions to the delay-code controller. It also tracks decision dithering to flag loop lock.

## Interface
- `MW`, 2: width of `M_counter` and `M`.
- `NW`, 4: width of `N_counter` and `N`.
- `QW`, 10: delay-code width.
- `VOTE_LEN`, 8: accepted samples per vote window (≥1).
- `TH_HI`, 6: lead count at or above this value gives decision UP.
- `TH_LO`, 2: lead count at or below this value gives decision DN. Constraint: `TH_LO < TH_HI ≤ VOTE_LEN`.
- `HOLDOFF`, 1: qualified strobes discarded after each UP/DN decision (0 = none).
- `LOCK_CNT`, 4: consecutive non-monotone windows required to assert `LOCK`.

Ports:
- `clk_ext` in 1: the single clock; everything is rising-edge.
- `Reset_PD` in 1: asynchronous, active-high reset.
- `enable` in 1: synchronous run enable.
- `clk_out` in 1: DLL output; its level at the strobe edge is the sample.
- `M_counter` in MW, `N_counter` in NW: loop counters.
- `M` in MW, `N` in NW: compare position.
- `Q`, `Q_next` in QW: current and next delay code.
- `COMP` out 1: registered last non-dead decision (1 = lead/UP).
- `UP`, `DN` out 1: one-cycle decision pulses, mutually exclusive.
- `LOCK` out 1: lock flag.

## Operation
- Strobe: `stb = enable & (M_counter==M) & (N_counter==N) & (Q==Q_next)`. When `Q != Q_next`, the strobe is suppressed. It is not counted and does not advance the window.
- FSM states:
  - IDLE: entered when `enable=0`.
    - Exits to HOLD if `HOLDOFF>0`, otherwise to COLLECT, on the first `enable=1` cycle.
    - Clears the sample count, lead count and holdoff count.
  - HOLD: each `stb` increments `ho_cnt`. When the `stb` makes the count equal `HOLDOFF`, the FSM goes to COLLECT and `ho_cnt` returns to 0. Samples taken in HOLD are discarded.
  - COLLECT: each `stb` adds 1 to `s_cnt` and adds `clk_out` to `lead_cnt`. Both counters are `$clog2(VOTE_LEN+1)` bits wide. On the `stb` that completes the window (`s_cnt==VOTE_LEN-1`), the FSM evaluates `total = lead_cnt + clk_out` in the same edge:
    - `total ≥ TH_HI`: decision UP. `COMP←1`, `UP` pulses, next state HOLD (or COLLECT if `HOLDOFF=0`).
    - `total ≤ TH_LO`: decision DN. `COMP←0`, `DN` pulses, same next state.
    - Otherwise: decision DEAD. `COMP` holds, no pulse, the FSM stays in COLLECT.
    - In all three cases `s_cnt` and `lead_cnt` clear.
- Lock tracking uses `last_dir ∈ {NONE, UP, DN}` and a saturating `lk_cnt` in `0..LOCK_CNT`. Rules are evaluated per window decision:
  - DEAD, or a direction opposite to `last_dir`: `lk_cnt` increments (saturating).
  - Same direction as `last_dir`: `lk_cnt←0`.
  - Direction when `last_dir=NONE`: `lk_cnt` unchanged.
  - `last_dir` updates on UP/DN only.
  - `LOCK` is registered as `lk_cnt==LOCK_CNT`, taking effect on the same edge as the decision.
- `enable` falling:
  - Next edge: FSM to IDLE, `UP=DN=0`, `LOCK←0`, `lk_cnt←0`, `last_dir←NONE`.
  - `COMP` holds.
- Reset (async, any time, including mid-window):
  - Outputs: `COMP=0`, `UP=0`, `DN=0`, `LOCK=0`.
  - Internal: FSM in IDLE, all counters 0, `last_dir=NONE`.
  - The first rising edge after deassertion follows normal `enable` rules.

## Timing
- Decision latency: `COMP`, `UP`/`DN` and `LOCK` update on the rising edge that captures the window-completing strobe. Pulses are high for exactly one `clk_ext` cycle.
- Minimum decision spacing: `VOTE_LEN+HOLDOFF` qualified strobes.
- A strobe coinciding with `enable` falling is ignored, because the strobe requires `enable`.
- A strobe on the cycle after IDLE exit is valid.
- `clk_out` is used raw, with no synchroniser; metastability is accepted as part of the phase decision.
- Counters never wrap: `s_cnt` and `ho_cnt` clear on reaching their terminal value; `lk_cnt` saturates.

## Test plan
Defaults throughout, with M=3 and N=9.
- **Reset:** assert `Reset_PD` mid-window with 5 samples taken → outputs 0 immediately, asynchronously. After release, 8 strobes with `clk_out=1` → `UP` pulses once, `COMP=1`; the earlier 5 samples are not counted.
- **Qualification:** 8 strobes with `clk_out=1`, `Q != Q_next` on 3 of them → no decision. 3 more valid strobes → `UP`, `COMP=1`.
- **Thresholds and holdoff:**
  - Window with 2 leads → `DN`, `COMP=0`.
  - Window with 6 leads → `UP`.
  - Window with 4 leads → no pulse, `COMP` unchanged, the next strobe counts in a new window.
  - After each UP/DN, exactly 1 strobe is discarded.
- **Lock:**
  - Windows UP, DN, UP, DN, DEAD → `LOCK` rises on the 5th decision edge (first UP does not count).
  - Then UP, UP → `LOCK` falls on the second UP.
- **Enable:**
  - Deassert `enable` while `LOCK=1` → `LOCK=0` next edge, `COMP` held.
  - Re-enable → 1 strobe holdoff, then a full 8-sample window is required before any decision.

Source files
------------

// File: rtl/pd_vote_if.sv
// rtl/pd_vote_if.sv - signal bundle between the phase-detector core and its loop environment
//
// Purpose: groups the run enable, sampled clock, counter/compare positions,
//          delay codes and the decision outputs of pd_vote.
// Ports (slave = pd_vote side):
//   enable           in   synchronous run enable
//   clk_out          in   DLL output, sampled raw at the strobe edge
//   M_counter, M     in   MW-bit loop counter and compare position
//   N_counter, N     in   NW-bit loop counter and compare position
//   Q, Q_next        in   QW-bit current and next delay code
//   COMP             out  last non-dead decision (1 = lead/UP)
//   UP, DN           out  one-cycle decision pulses
//   LOCK             out  lock flag
interface pd_vote_if #(
  parameter int MW = 2,
  parameter int NW = 4,
  parameter int QW = 10
);
  logic          enable;
  logic          clk_out;
  logic [MW-1:0] M_counter;
  logic [MW-1:0] M;
  logic [NW-1:0] N_counter;
  logic [NW-1:0] N;
  logic [QW-1:0] Q;
  logic [QW-1:0] Q_next;
  logic          COMP;
  logic          UP;
  logic          DN;
  logic          LOCK;

  modport master (
    output enable, clk_out, M_counter, M, N_counter, N, Q, Q_next,
    input  COMP, UP, DN, LOCK
  );

  modport slave (
    input  enable, clk_out, M_counter, M, N_counter, N, Q, Q_next,
    output COMP, UP, DN, LOCK
  );
endinterface

// File: rtl/pd_vote.sv
// rtl/pd_vote.sv - majority-vote phase detector with holdoff and dither-based lock detection
//
// Purpose: samples clk_out at a programmable (M, N) counter position while the
//          delay code is settled, votes over VOTE_LEN samples and emits filtered
//          UP/DN decisions; counts non-monotone windows to raise LOCK.
// Ports:
//   clk_ext   in   the only clock, rising edge
//   Reset_PD  in   asynchronous active-high reset
//   pd        slave modport of pd_vote_if (inputs: enable, clk_out, counters,
//             compare positions, Q/Q_next; outputs: COMP, UP, DN, LOCK)
module pd_vote #(
  parameter int VOTE_LEN = 8,
  parameter int TH_HI    = 6,
  parameter int TH_LO    = 2,
  parameter int HOLDOFF  = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic      clk_ext,
  input  logic      Reset_PD,
  pd_vote_if.slave  pd
);

  localparam int SW = $clog2(VOTE_LEN + 1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int LW = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;

  localparam logic [SW-1:0] S_LAST  = SW'(VOTE_LEN - 1);
  localparam logic [SW-1:0] TH_HI_V = SW'(TH_HI);
  localparam logic [SW-1:0] TH_LO_V = SW'(TH_LO);
  localparam logic [HW-1:0] HO_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [LW-1:0] LK_MAX  = LW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, HOLD, COLLECT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  // After an UP/DN decision the loop needs time to settle, so skip to HOLD
  // unless no holdoff is configured.
  localparam state_t POST = (HOLDOFF > 0) ? HOLD : COLLECT;

  state_t        state;
  dir_t          last_dir;
  logic [SW-1:0] s_cnt;
  logic [SW-1:0] lead_cnt;
  logic [HW-1:0] ho_cnt;
  logic [LW-1:0] lk_cnt;
  logic          comp_q;
  logic          up_q;
  logic          dn_q;
  logic          lock_q;

  logic          stb;
  logic [SW-1:0] total;
  logic          dec_up;
  logic          dec_dn;
  logic [LW-1:0] lk_inc;
  logic [LW-1:0] lk_nxt;

  always_comb begin
    stb    = pd.enable & (pd.M_counter == pd.M) & (pd.N_counter == pd.N) &
             (pd.Q == pd.Q_next);
    // Includes the current sample so the window-completing strobe counts.
    total  = lead_cnt + SW'(pd.clk_out);
    dec_up = (total >= TH_HI_V);
    dec_dn = !dec_up && (total <= TH_LO_V);
    lk_inc = (lk_cnt == LK_MAX) ? lk_cnt : lk_cnt + LW'(1);
    // DEAD or a reversal means the loop is dithering around the lock point;
    // a repeated direction means it is still slewing.
    lk_nxt = lk_inc;
    if (dec_up) begin
      if (last_dir == DIR_NONE)    lk_nxt = lk_cnt;
      else if (last_dir == DIR_UP) lk_nxt = '0;
    end else if (dec_dn) begin
      if (last_dir == DIR_NONE)    lk_nxt = lk_cnt;
      else if (last_dir == DIR_DN) lk_nxt = '0;
    end
  end

  always_ff @(posedge clk_ext or posedge Reset_PD) begin
    if (Reset_PD) begin
      state    <= IDLE;
      last_dir <= DIR_NONE;
      s_cnt    <= '0;
      lead_cnt <= '0;
      ho_cnt   <= '0;
      lk_cnt   <= '0;
      comp_q   <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      up_q <= 1'b0;
      dn_q <= 1'b0;
      if (!pd.enable) begin
        // COMP deliberately keeps the last decision across a disable.
        state    <= IDLE;
        s_cnt    <= '0;
        lead_cnt <= '0;
        ho_cnt   <= '0;
        lk_cnt   <= '0;
        last_dir <= DIR_NONE;
        lock_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= (HOLDOFF > 0) ? HOLD : COLLECT;
            s_cnt    <= '0;
            lead_cnt <= '0;
            ho_cnt   <= '0;
          end
          HOLD: begin
            if (stb) begin
              if (ho_cnt == HO_LAST) begin
                ho_cnt <= '0;
                state  <= COLLECT;
              end else begin
                ho_cnt <= ho_cnt + HW'(1);
              end
            end
          end
          COLLECT: begin
            if (stb) begin
              if (s_cnt == S_LAST) begin
                s_cnt    <= '0;
                lead_cnt <= '0;
                lk_cnt   <= lk_nxt;
                lock_q   <= (lk_nxt == LK_MAX);
                if (dec_up) begin
                  comp_q   <= 1'b1;
                  up_q     <= 1'b1;
                  last_dir <= DIR_UP;
                  state    <= POST;
                end else if (dec_dn) begin
                  comp_q   <= 1'b0;
                  dn_q     <= 1'b1;
                  last_dir <= DIR_DN;
                  state    <= POST;
                end
              end else begin
                s_cnt    <= s_cnt + SW'(1);
                lead_cnt <= total;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign pd.COMP = comp_q;
  assign pd.UP   = up_q;
  assign pd.DN   = dn_q;
  assign pd.LOCK = lock_q;

endmodule

// File: tb/tb_pd_vote.sv
// tb/tb_pd_vote.sv - scoreboard bench for pd_vote with a window-level reference model
module tb_pd_vote;

  localparam int VOTE_LEN = 8;
  localparam int TH_HI    = 6;
  localparam int TH_LO    = 2;
  localparam int HOLDOFF  = 1;
  localparam int LOCK_CNT = 4;
  localparam logic [1:0] MPOS = 2'd3;
  localparam logic [3:0] NPOS = 4'd9;

  logic clk_ext  = 1'b0;
  logic Reset_PD = 1'b0;

  pd_vote_if #(.MW(2), .NW(4), .QW(10)) bus ();

  pd_vote #(
    .VOTE_LEN(VOTE_LEN), .TH_HI(TH_HI), .TH_LO(TH_LO),
    .HOLDOFF(HOLDOFF), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk_ext (clk_ext),
    .Reset_PD(Reset_PD),
    .pd      (bus)
  );

  always #5 clk_ext = ~clk_ext;

  int cyc = 0;
  always @(posedge clk_ext) cyc++;

  typedef struct {
    int cyc;
    bit val;
  } ev_t;

  ev_t pulse_q[$];
  ev_t comp_q[$];
  ev_t lock_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: counts accepted samples per window and applies the
  // vote / lock rules directly on integers.
  bit m_idle = 1'b1;
  int m_hold = 0;
  int m_n = 0;
  int m_leads = 0;
  int m_lk = 0;
  int m_dir = 0;
  bit m_comp = 1'b0;
  bit m_lock = 1'b0;

  task automatic model_step(input bit en, input bit stb, input bit co);
    ev_t e;
    int  dir;
    bit  new_lock;
    e.cyc = cyc + 1;
    if (!en) begin
      if (m_lock) begin e.val = 1'b0; lock_q.push_back(e); end
      m_lock = 0; m_lk = 0; m_dir = 0; m_idle = 1; m_n = 0; m_leads = 0; m_hold = 0;
    end else if (m_idle) begin
      m_idle = 0; m_hold = HOLDOFF; m_n = 0; m_leads = 0;
    end else if (stb) begin
      if (m_hold > 0) begin
        m_hold--;
      end else begin
        m_n++;
        m_leads += co;
        if (m_n == VOTE_LEN) begin
          dir = (m_leads >= TH_HI) ? 1 : (m_leads <= TH_LO) ? -1 : 0;
          if (dir == 0 || (m_dir != 0 && dir == -m_dir))
            m_lk = (m_lk < LOCK_CNT) ? m_lk + 1 : m_lk;
          else if (m_dir != 0)
            m_lk = 0;
          new_lock = (m_lk == LOCK_CNT);
          if (new_lock != m_lock) begin e.val = new_lock; lock_q.push_back(e); end
          m_lock = new_lock;
          if (dir != 0) begin
            e.val = (dir == 1);
            pulse_q.push_back(e);
            if (m_comp != (dir == 1)) comp_q.push_back(e);
            m_comp = (dir == 1);
            m_dir  = dir;
            m_hold = HOLDOFF;
          end
          m_n = 0;
          m_leads = 0;
        end
      end
    end
  endtask

  task automatic apply(input bit en, input bit co, input bit hit, input bit qok);
    logic [9:0] q;
    bus.enable  = en;
    bus.clk_out = co;
    if (hit) begin
      bus.M_counter = MPOS;
      bus.N_counter = NPOS;
    end else begin
      bus.M_counter = 2'($urandom_range(0, 3));
      bus.N_counter = 4'($urandom_range(0, 15));
      if (bus.M_counter == MPOS && bus.N_counter == NPOS) bus.N_counter = NPOS + 4'd1;
    end
    q = 10'($urandom_range(0, 1023));
    bus.Q      = q;
    bus.Q_next = qok ? q : q + 10'd1;
    model_step(en, en & hit & qok, co);
  endtask

  task automatic drive(input bit en, input bit co, input bit hit, input bit qok);
    @(negedge clk_ext);
    apply(en, co, hit, qok);
  endtask

  task automatic strobe(input bit co, input bit qok);
    drive(1'b1, co, 1'b1, qok);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic window(input int leads);
    for (int i = 0; i < VOTE_LEN; i++) strobe(i < leads, 1'b1);
  endtask

  task automatic do_reset();
    ev_t e;
    @(negedge clk_ext);
    #2 Reset_PD = 1'b1;
    e.cyc = cyc + 1;
    e.val = 1'b0;
    if (m_comp) comp_q.push_back(e);
    if (m_lock) lock_q.push_back(e);
    m_comp = 0; m_lock = 0; m_idle = 1; m_hold = 0; m_n = 0; m_leads = 0; m_lk = 0; m_dir = 0;
    #1;
    check("reset_COMP", bus.COMP, 0);
    check("reset_UP",   bus.UP,   0);
    check("reset_DN",   bus.DN,   0);
    check("reset_LOCK", bus.LOCK, 0);
    @(negedge clk_ext);
    Reset_PD = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: pops an expectation whenever the DUT shows a pulse or a level change.
  bit   mon_on = 1'b0;
  logic prev_comp;
  logic prev_lock;
  ev_t  mon_e;

  always @(negedge clk_ext) begin
    if (mon_on) begin
      if (bus.UP === 1'b1 && bus.DN === 1'b1) begin
        check("up_dn_exclusive", {bus.UP, bus.DN}, 2'b01);
      end else if (bus.UP === 1'b1 || bus.DN === 1'b1) begin
        if (pulse_q.size() == 0) begin
          check("unexpected_pulse", pulse_q.size(), 1);
        end else begin
          mon_e = pulse_q.pop_front();
          check("pulse_cycle", cyc, mon_e.cyc);
          check("pulse_is_UP", bus.UP, mon_e.val);
        end
      end
      if (bus.COMP !== prev_comp) begin
        if (comp_q.size() == 0) begin
          check("unexpected_COMP_change", comp_q.size(), 1);
        end else begin
          mon_e = comp_q.pop_front();
          check("COMP_cycle", cyc, mon_e.cyc);
          check("COMP_value", bus.COMP, mon_e.val);
        end
        prev_comp = bus.COMP;
      end
      if (bus.LOCK !== prev_lock) begin
        if (lock_q.size() == 0) begin
          check("unexpected_LOCK_change", lock_q.size(), 1);
        end else begin
          mon_e = lock_q.pop_front();
          check("LOCK_cycle", cyc, mon_e.cyc);
          check("LOCK_value", bus.LOCK, mon_e.val);
        end
        prev_lock = bus.LOCK;
      end
    end
  end

  initial begin
    int  bias;
    bit  en_state;
    int  r;
    bus.M = MPOS;
    bus.N = NPOS;
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    #1 Reset_PD = 1'b1;
    #1;
    check("init_COMP", bus.COMP, 0);
    check("init_UP",   bus.UP,   0);
    check("init_DN",   bus.DN,   0);
    check("init_LOCK", bus.LOCK, 0);
    @(negedge clk_ext);
    Reset_PD  = 1'b0;
    prev_comp = bus.COMP;
    prev_lock = bus.LOCK;
    mon_on    = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-window: five samples already taken must be forgotten.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    strobe(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1);
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    strobe(1'b0, 1'b1);
    window(8);
    check("COMP_after_reset_window", bus.COMP, 1);

    // Qualification: unsettled delay code suppresses the strobe.
    strobe(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) strobe(1'b1, !(i == 1 || i == 4 || i == 6));
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1);

    // Thresholds and holdoff.
    strobe(1'b1, 1'b1);
    window(2);
    check("COMP_after_2_leads", bus.COMP, 0);
    strobe(1'b0, 1'b1);
    window(6);
    check("COMP_after_6_leads", bus.COMP, 1);
    strobe(1'b0, 1'b1);
    window(4);
    check("COMP_after_dead", bus.COMP, 1);
    window(2);
    check("COMP_after_dead_then_2", bus.COMP, 0);

    // Lock: UP DN UP DN DEAD raises, UP UP drops.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 4; w++) begin
      strobe(1'b0, 1'b1);
      window((w % 2 == 0) ? 8 : 0);
    end
    strobe(1'b0, 1'b1);
    window(4);
    check("LOCK_after_dither", bus.LOCK, 1);
    window(8);
    strobe(1'b0, 1'b1);
    window(8);
    check("LOCK_after_UP_UP", bus.LOCK, 0);

    // Re-lock with COMP=1, then disable and re-enable.
    for (int w = 0; w < 4; w++) begin
      strobe(1'b0, 1'b1);
      window((w % 2 == 0) ? 0 : 8);
    end
    check("LOCK_before_disable", bus.LOCK, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("LOCK_after_disable", bus.LOCK, 0);
    check("COMP_held_on_disable", bus.COMP, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    strobe(1'b0, 1'b1);
    window(0);

    // Randomized phase.
    bias = 50;
    en_state = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 24 == 0) begin
        case ($urandom_range(0, 4))
          0: bias = 0;
          1: bias = 15;
          2: bias = 50;
          3: bias = 85;
          default: bias = 100;
        endcase
      end
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset();
      end else begin
        if (en_state && $urandom_range(0, 99) < 1) en_state = 1'b0;
        else if (!en_state && $urandom_range(0, 99) < 30) en_state = 1'b1;
        drive(en_state, $urandom_range(0, 99) < bias,
              $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 85);
      end
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("pulse_queue_drained", pulse_q.size(), 0);
    check("COMP_queue_drained",  comp_q.size(),  0);
    check("LOCK_queue_drained",  lock_q.size(),  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
